// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared deserializer types and default word width
package deser_pkg;

    typedef enum logic {RECEIVING, READY} deser_state_t;

    localparam int DESER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial-to-parallel word collector with ready/ack handshake
// Shifts one bit per write_in into a WIDTH-bit word, MSB first, and holds it until acked.
module deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
    input  logic             clk_100KHz,
    input  logic             reset,
    input  logic             data_in,
    input  logic             write_in,
    input  logic             ack_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_ready,
    output logic             status_out,
    output logic             overrun_out
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    deser_state_t     state;
    deser_state_t     next_state;
    logic [CNT_W-1:0] bit_cnt;
    // Only WIDTH-1 bits are stored; the final bit goes straight into data_out.
    logic [WIDTH-2:0] shift;
    logic [WIDTH-1:0] word_next;
    logic             take_bit;
    logic             last_bit;
    logic             ready_q;

    assign word_next = {shift, data_in};
    assign take_bit  = (state == RECEIVING) && write_in;
    assign last_bit  = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            state <= RECEIVING;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RECEIVING: if (write_in && last_bit) next_state = READY;
            READY:     if (ack_in)               next_state = RECEIVING;
            default:                             next_state = RECEIVING;
        endcase
    end

    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            shift       <= '0;
            bit_cnt     <= '0;
            data_out    <= '0;
            ready_q     <= 1'b0;
            overrun_out <= 1'b0;
        end else if (take_bit) begin
            shift <= word_next[WIDTH-2:0];
            if (last_bit) begin
                data_out <= word_next;
                ready_q  <= 1'b1;
                bit_cnt  <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else if (state == READY) begin
            // Ack wins over a simultaneous write: that bit is dropped without flagging overrun.
            if (ack_in) begin
                ready_q     <= 1'b0;
                overrun_out <= 1'b0;
            end else if (write_in) begin
                overrun_out <= 1'b1;
            end
        end
    end

    assign data_ready = ready_q;
    assign status_out = ready_q;

endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel stage directly downstream of the clock divider. It runs on the divider's 100 kHz output and collects one data bit per qualified cycle into a WIDTH-bit word. It presents each completed word with a ready/acknowledge handshake to the slower (10 kHz-domain) queue stage. It raises a busy status so the serial source stalls while a word is waiting to be taken.

## Interface
- WIDTH, 8, bits per word (≥ 2)
- clk_100KHz  input  1  sole clock, rising edge (100 kHz output of the divider)
- reset  input  1  asynchronous, active-high; clears all state immediately
- data_in  input  1  serial data bit, sampled when write_in = 1
- write_in  input  1  bit-valid strobe from the serial source
- ack_in  input  1  word-accepted strobe from the consumer
- data_out  output  WIDTH  last completed word, first-received bit in MSB
- data_ready  output  1  completed word held in data_out, awaiting ack
- status_out  output  1  busy: 1 while a word is held (source must not write)
- overrun_out  output  1  sticky error: write attempted while busy

## Operation
- FSM, two states: RECEIVING (reset state), READY.
- RECEIVING:
  - On each edge with write_in = 1: shift register ← {shift[WIDTH-2:0], data_in}; bit counter +1.
  - write_in = 0: shift register and counter hold. Gaps of any length are allowed.
  - ack_in is ignored.
  - When the bit being sampled is the WIDTH-th (counter = WIDTH-1), that edge:
    - loads data_out ← {shift[WIDTH-2:0], data_in};
    - sets data_ready = 1 and status_out = 1;
    - clears the counter;
    - enters READY.
- READY:
  - write_in = 1 with ack_in = 0: the bit is discarded and overrun_out ← 1.
  - ack_in = 1: clears data_ready, status_out and overrun_out, then returns to RECEIVING.
    - A write_in in the same cycle as ack_in is discarded (FSM is still READY on that edge) and does not set overrun.
- data_out holds its value from one completed word to the next. It is never cleared by ack.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1. There is no wrap past a word boundary without passing through READY.
- A partially collected word is never visible on data_out.

## Timing
- Reset values: data_out = 0, data_ready = 0, status_out = 0, overrun_out = 0, counter = 0, shift register = 0, state = RECEIVING.
- All outputs are registered. There is no combinational path from input to output.
- Latency: data_ready and data_out are valid immediately after the edge that samples the final bit, i.e. 0 extra cycles.
- Ack release: data_ready, status_out and overrun_out fall after the edge on which ack_in = 1 is sampled. The first bit of the next word is accepted on the following edge at the earliest.
- Minimum word period: WIDTH + 1 cycles. That is WIDTH bit cycles plus one ack cycle.
- ack_in may be held high for several cycles. Extra cycles in RECEIVING have no effect.
- Reset asserted mid-word or while READY discards everything and returns to the reset values asynchronously. After reset deasserts, collection restarts at bit 0.

## Structure
- Shared package deser_pkg holds:
  - typedef enum logic {RECEIVING, READY} deser_state_t;
  - localparam DESER_WIDTH_DEFAULT = 8, which also sets the default for WIDTH.
- The queue stage imports the same package for the word width.
- Flat module. No sub-module is natural; the shift register, counter and FSM are each a few lines and share the same enable.

## Test plan
- Reset then bits 1,0,1,0,0,1,0,1 on 8 consecutive write_in cycles -> after the 8th edge: data_out = 8'hA5, data_ready = 1, status_out = 1, overrun_out = 0.
- Same word with write_in dropped for 3 cycles between bits 4 and 5 -> identical result, 11 cycles after the first bit.
- Word 8'hA5 held, ack_in pulsed for 1 cycle -> next edge data_ready = 0 and status_out = 0, data_out stays 8'hA5. Next word 8'h3C -> data_out = 8'h3C.
- Word 8'h5A held, write_in = 1 with data_in = 1 for 2 cycles without ack -> overrun_out = 1, data_out still 8'h5A. Then ack -> overrun_out = 0. Next word is assembled from fresh bits only.
- 3 bits (1,1,1) sent, reset pulsed asynchronously between edges -> outputs return to 0 immediately. Then 0,0,1,1,1,1,0,0 -> data_out = 8'h3C, not corrupted by the earlier bits.
- Word held, ack_in and write_in both high for one cycle -> data_ready falls and overrun_out stays 0. A full new word 8'hFF then completes in exactly 8 write cycles.
